md_sequencer: RTL and testbench

Multiply/divide scheduler for the E-stage HI/LO resource of the pipelined MIPS core. Accepts one MD operation per start pulse and models fixed mult/div latency with a countdown FSM. Commits HI/LO atomically at the end of the operation and exports busy/stall to the hazard unit. Honours the CP0 exception request (req) by cancelling in-flight work, so an exception leaves HI/LO unchanged.

---
 rtl/md_pkg.sv | 25 ++
 rtl/md_arith.sv | 64 ++++++
 rtl/md_sequencer.sv | 131 +++++++++++++
 tb/tb_md_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
//   md_op_t    : MD opcode carried on the op port
//   md_state_t : sequencer state encoding
//   *_DEF      : default mult/div latencies in cycles
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_t;

  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result generator for mult/multu/div/divu.
//   op       : md_pkg opcode
//   in1, in2 : rs / rt operands
//   hi_res   : product[63:32] or remainder
//   lo_res   : product[31:0]  or quotient
//   div_zero : div/divu with in2 == 0 (result must not be committed)
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_zero
);

  logic        is_signed;
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  // One shared multiplier and one shared magnitude divider serve both the
  // signed and unsigned forms. Sign-magnitude division gives truncation
  // toward zero with the remainder following the dividend, and makes
  // 0x80000000 / -1 come out as quotient 0x80000000, remainder 0.
  always_comb begin
    is_signed = (op == MD_MULT) || (op == MD_DIV);
    a_ext     = is_signed ? {{32{in1[31]}}, in1} : {32'h0, in1};
    b_ext     = is_signed ? {{32{in2[31]}}, in2} : {32'h0, in2};
    prod      = a_ext * b_ext;

    a_neg = is_signed & in1[31];
    b_neg = is_signed & in2[31];
    a_mag = a_neg ? (32'h0 - in1) : in1;
    b_mag = b_neg ? (32'h0 - in2) : in2;

    q_mag = '0;
    r_mag = '0;
    if (b_mag != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? (32'h0 - q_mag) : q_mag;
    rem  = a_neg ? (32'h0 - r_mag) : r_mag;

    div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (in2 == '0);

    hi_res = '0;
    lo_res = '0;
    case (op)
      MD_MULT, MD_MULTU: begin
        hi_res = prod[63:32];
        lo_res = prod[31:0];
      end
      MD_DIV, MD_DIVU: begin
        hi_res = rem;
        lo_res = quot;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide scheduler owning the architectural HI/LO registers.
// Latches an MD result on start, holds busy for a fixed latency, then
// commits HI/LO atomically; a CP0 request cancels in-flight work.
//   clk, reset : clock, async active-low reset
//   req        : CP0 exception request (flushes E stage)
//   start, op  : E-stage MD instruction valid / opcode
//   in1, in2   : forwarded rs / rt operands
//   md_use_D   : D-stage instruction touches HI/LO
//   busy       : operation in progress
//   stall      : hold D stage on HI/LO hazard
//   done       : one-cycle pulse in the commit cycle
//   HI, LO     : architectural HI / LO
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;

  logic [31:0] hi_res, lo_res;
  logic        div_zero;
  logic        is_md, is_mul;

  md_arith u_arith (
    .op       (op),
    .in1      (in1),
    .in2      (in2),
    .hi_res   (hi_res),
    .lo_res   (lo_res),
    .div_zero (div_zero)
  );

  assign is_mul = (op == MD_MULT) || (op == MD_MULTU);
  assign is_md  = is_mul || (op == MD_DIV) || (op == MD_DIVU);

  assign busy  = (state_q == RUN);
  assign stall = md_use_D & (busy | (start & is_md & ~req));
  assign HI    = hi_q;
  assign LO    = lo_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !req) begin
          case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              pend_hi_d = hi_res;
              pend_lo_d = lo_res;
              // Divide by zero still runs its full latency but never commits.
              pend_wr_d = !div_zero;
              cnt_d     = is_mul ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
              state_d   = RUN;
            end
            MD_MTHI: hi_d = in1;
            MD_MTLO: lo_d = in1;
            default: ;
          endcase
        end
      end
      RUN: begin
        // A CP0 request outranks the commit, even on the final count.
        if (req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          done    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer.
module tb_md_sequencer;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        reset, req, start, md_use_D;
  logic [2:0]  op;
  logic [31:0] in1, in2;
  logic        busy, stall, done;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  md_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .start(start), .op(op),
    .in1(in1), .in2(in2), .md_use_D(md_use_D),
    .busy(busy), .stall(stall), .done(done), .HI(HI), .LO(LO)
  );

  // The hazard unit never issues an MD op while busy.
  always @(posedge clk) begin
    if (reset === 1'b1 && busy === 1'b1 && start === 1'b1) begin
      errors++;
      $display("FAIL start_while_busy at %0t", $time);
    end
  end

  task automatic idle_inputs();
    start = 1'b0; op = OP_NONE; in1 = '0; in2 = '0; req = 1'b0;
  endtask

  // Presents one op for one cycle; returns 1ns into the following cycle.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; in1 = a; in2 = b;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
  endtask

  task automatic test_reset();
    reset = 1'b0; md_use_D = 1'b0; idle_inputs();
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", HI); end
    checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", LO); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    issue(OP_MTHI, 32'hAAAA5555, 32'h0);
    issue(OP_MTLO, 32'h5555AAAA, 32'h0);
    checks++; if (HI !== 32'hAAAA5555 || LO !== 32'h5555AAAA) begin
      errors++; $display("FAIL mt_preload: got %h/%h want aaaa5555/5555aaaa", HI, LO); end
    issue(OP_MULT, 32'd3, 32'd4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %b want 1", busy); end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrun_reset_busy: got %b want 0", busy); end
    checks++; if (HI !== 32'h0 || LO !== 32'h0) begin
      errors++; $display("FAIL midrun_reset_hilo: got %h/%h want 0/0", HI, LO); end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; op = OP_MTHI; in1 = 32'h12345678;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    checks++; if (HI !== 32'h12345678) begin errors++; $display("FAIL mthi: got %h want 12345678", HI); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mthi_busy_done: got %b%b want 00", busy, done); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy_later: got %b want 0", busy); end
    exp_hi = 32'h12345678; exp_lo = 32'h0;
  endtask

  // Runs an MD op and checks busy/done per cycle, then the committed HI/LO.
  task automatic run_and_check(input string nm, input logic [2:0] o,
                               input logic [31:0] a, input logic [31:0] b,
                               input int n, input logic [31:0] nh, input logic [31:0] nl);
    issue(o, a, b);
    for (int k = 1; k <= n; k++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy c%0d: got %b want 1", nm, k, busy); end
      checks++; if (done !== (k == n)) begin errors++; $display("FAIL %s_done c%0d: got %b want %b", nm, k, done, k == n); end
      checks++; if (HI !== exp_hi || LO !== exp_lo) begin
        errors++; $display("FAIL %s_early c%0d: got %h/%h want %h/%h", nm, k, HI, LO, exp_hi, exp_lo); end
      @(posedge clk); #1;
    end
    exp_hi = nh; exp_lo = nl;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL %s_end: got busy=%b done=%b want 0 0", nm, busy, done); end
    checks++; if (HI !== exp_hi || LO !== exp_lo) begin
      errors++; $display("FAIL %s_result: got %h/%h want %h/%h", nm, HI, LO, exp_hi, exp_lo); end
  endtask

  task automatic test_mult();
    run_and_check("mult",  OP_MULT,  32'hFFFFFFFD, 32'd5, MUL_N, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_and_check("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, MUL_N, 32'h00000001, 32'hFFFFFFFE);
  endtask

  task automatic test_div();
    run_and_check("div",      OP_DIV,  32'hFFFFFFF9, 32'd2,        DIV_N, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_and_check("divu_z",   OP_DIVU, 32'd7,        32'd0,        DIV_N, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_and_check("div_ovf",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, DIV_N, 32'h00000000, 32'h80000000);
    run_and_check("divu_big", OP_DIVU, 32'hFFFFFFF0, 32'd3,        DIV_N, 32'h00000000, 32'h55555550);
  endtask

  task automatic test_req();
    issue(OP_DIV, 32'd100, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req = 1'b1;
    #1;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL req_c3: got busy=%b done=%b want 1 0", busy, done); end
    @(posedge clk); #1 req = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL req_cancel_busy: got %b want 0", busy); end
    for (int k = 0; k < DIV_N + 2; k++) begin
      checks++; if (done !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
        errors++; $display("FAIL req_aftermath c%0d: got done=%b %h/%h want 0 %h/%h", k, done, HI, LO, exp_hi, exp_lo); end
      @(posedge clk); #1;
    end
    // start together with req: nothing happens
    start = 1'b1; op = OP_MULT; in1 = 32'd2; in2 = 32'd3; req = 1'b1;
    @(posedge clk); #1;
    op = OP_MTHI; in1 = 32'hDEADBEEF;
    @(posedge clk); #1;
    idle_inputs();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL req_start_busy: got %b want 0", busy); end
    checks++; if (HI !== exp_hi || LO !== exp_lo) begin
      errors++; $display("FAIL req_start_hilo: got %h/%h want %h/%h", HI, LO, exp_hi, exp_lo); end
    // req on the final count beats the commit
    issue(OP_MULT, 32'd2, 32'd3);
    repeat (MUL_N - 1) begin @(posedge clk); #1; end
    req = 1'b1;
    #1;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL req_last_done: got done=%b busy=%b want 0 1", done, busy); end
    @(posedge clk); #1 req = 1'b0;
    checks++; if (busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
      errors++; $display("FAIL req_last_hilo: got busy=%b %h/%h want 0 %h/%h", busy, HI, LO, exp_hi, exp_lo); end
  endtask

  task automatic test_stall();
    md_use_D = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; op = OP_MULT; in1 = 32'd6; in2 = 32'd7;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_start: got %b want 1", stall); end
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    for (int k = 1; k <= MUL_N; k++) begin
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_busy c%0d: got %b want 1", k, stall); end
      @(posedge clk); #1;
    end
    exp_hi = 32'h0; exp_lo = 32'd42;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_after: got %b want 0", stall); end
    checks++; if (HI !== exp_hi || LO !== exp_lo) begin
      errors++; $display("FAIL stall_result: got %h/%h want %h/%h", HI, LO, exp_hi, exp_lo); end
    md_use_D = 1'b0;
    start = 1'b1; op = OP_MULT; in1 = 32'd1; in2 = 32'd1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nostall_start: got %b want 0", stall); end
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    for (int k = 1; k <= MUL_N; k++) begin
      checks++; if (stall !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL nostall_busy c%0d: got stall=%b busy=%b want 0 1", k, stall, busy); end
      @(posedge clk); #1;
    end
    checks++; if (LO !== 32'd1 || HI !== 32'h0) begin
      errors++; $display("FAIL nostall_result: got %h/%h want 00000000/00000001", HI, LO); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_req();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
